axi4_lite_mem_bridge: RTL and testbench
=======================================

# axi4_lite_mem_bridge

AXI4-lite subordinate that terminates one AXI4-lite manager link and converts each transaction into a single access on a simple request/ready word memory port. It sits directly downstream of the team's AXI4-lite interface, driving that interface's subordinate-side response signals. Typical targets are on-chip RAM or a register block. One transaction is in flight at a time. Reads and writes are arbitrated round-robin.

## Interface
- ADDR_WIDTH, 32, AXI byte-address width
- DATA_WIDTH, 32, data width (32 or 64); BOFF = $clog2(DATA_WIDTH/8)
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- arvalid/araddr  in  1/ADDR_WIDTH  read address channel
- arready  out  1
- rvalid/rdata  out  1/DATA_WIDTH  read data channel
- rready  in  1
- awvalid/awaddr  in  1/ADDR_WIDTH  write address channel
- awready  out  1
- wvalid/wdata  in  1/DATA_WIDTH  write data channel
- wready  out  1
- bvalid/bresp  out  1/3  write response; bresp[2] always 0; 0=OKAY, 2=SLVERR
- bready  in  1
- mem_req  out  1  memory access request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_WIDTH-BOFF  word address = addr[ADDR_WIDTH-1:BOFF]
- mem_wdata  out  DATA_WIDTH
- mem_rdata  in  DATA_WIDTH  valid in cycles where mem_ready=1 on a read
- mem_ready  in  1  access completes in the cycle mem_req && mem_ready

## Operation
- States: IDLE, WR_COLLECT, MEM_RD, MEM_WR, RD_RESP, WR_RESP.
- last_rd flag resets to 0. rd_sel = arvalid && !(last_rd && (awvalid || wvalid)).
- Ready outputs are decoded from state and gated low while aresetn=0:
  - arready = IDLE && rd_sel
  - awready = (IDLE && !rd_sel) || (WR_COLLECT && !have_aw)
  - wready = (IDLE && !rd_sel) || (WR_COLLECT && !have_w)
- IDLE:
  - AR handshake: capture araddr, set last_rd=1, go to MEM_RD.
  - AW and W handshake in the same cycle: capture both, go to MEM_WR.
  - Only one of AW or W handshakes: capture it, set have_aw or have_w, go to WR_COLLECT.
  - The write path clears last_rd when it leaves IDLE.
- WR_COLLECT: wait for the missing channel, then go to MEM_WR. Reads are not accepted in this state.
- MEM_RD: mem_req=1, mem_we=0. On mem_ready, latch mem_rdata into rdata and go to RD_RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata = captured wdata. On mem_ready, go to WR_RESP with bresp=0.
- RD_RESP: rvalid=1 with rdata stable until rready, then go to IDLE.
- WR_RESP: bvalid=1 with bresp stable until bready, then go to IDLE.
- Handshake rules:
  - mem_req and mem_addr/mem_we/mem_wdata are held stable until mem_ready.
  - No manager valid is dropped or reordered.
- Address low bits [BOFF-1:0] are ignored except when the alignment check is compiled in.

## Timing
- Reset values: state=IDLE, have_aw=have_w=0, last_rd=0, rvalid=bvalid=mem_req=mem_we=0, rdata=0, bresp=0, mem_addr=0, mem_wdata=0. arready/awready/wready are 0 while aresetn=0.
- Read, zero-wait memory:
  - AR handshake at cycle N.
  - mem_req at N+1; mem_ready at N+1.
  - rvalid at N+2.
  - Next AR can be accepted at the first cycle after the R handshake.
- Write, AW+W together at N: mem_req at N+1, bvalid at N+2.
- Each memory wait cycle adds one cycle of latency.
- Reset asserted mid-transaction: at the next edge all state is aborted, mem_req drops, and rvalid/bvalid drop. No response is produced for the aborted transaction.
- Simultaneous AR and AW/W in IDLE: grants alternate. After reset, a read wins first.

## Configuration
- AXI_MEM_BRIDGE_ALIGN_CHECK_EN defined:
  - A write with awaddr[BOFF-1:0]≠0 skips MEM_WR and goes straight to WR_RESP with bresp=2. No memory write occurs.
  - A misaligned read skips MEM_RD and returns rdata=0 in RD_RESP.
- Undefined: low address bits are ignored, all accesses reach memory, and bresp is always 0.

## Test plan
- Read, mem_ready tied 1: araddr=0x10 with memory word 4=0xCAFEF00D → mem_addr=4 at N+1, rvalid with rdata=0xCAFEF00D at N+2.
- Write with W two cycles before AW: wdata=0x12345678, awaddr=0x20 → one mem write to word 8 with 0x12345678, then bvalid with bresp=0. No arready during WR_COLLECT.
- Memory wait of 3 cycles plus rready held low 4 cycles → mem_req and rvalid remain stable throughout. Exactly one memory access occurs.
- AR and AW+W asserted continuously for 4 transactions after reset → order is read, write, read, write.
- aresetn pulsed low while in MEM_WR with mem_ready=0 → mem_req=0 after the edge, no bvalid, IDLE readies reassert the cycle after release.
- With the macro defined: awaddr=0x22 → bresp=2, no mem_req. Without it → mem write to word 8, bresp=0.

Source files
------------

// File: rtl/axi4_lite_mem_bridge.sv
// ---------------------------------------------------------------------------
// axi4_lite_mem_bridge
//
// AXI4-lite subordinate that turns each AXI4-lite transaction into exactly one
// access on a simple request/ready word-memory port. Only one transaction is
// in flight at a time. When a read and a write compete in IDLE, the grant
// alternates between them, and a read wins first after reset.
//
// Optional feature (compile-time macro):
//   AXI_MEM_BRIDGE_ALIGN_CHECK_EN
//     Defined   : a misaligned write skips memory and answers bresp=2 (SLVERR).
//                 A misaligned read skips memory and returns rdata=0.
//     Undefined : low address bits are ignored and every access reaches memory.
//
// Parameters
//   ADDR_WIDTH  AXI byte-address width (default 32)
//   DATA_WIDTH  data width, 32 or 64 (default 32)
//
// Ports
//   aclk, aresetn              clock (rising edge) and synchronous active-low reset
//   arvalid/araddr/arready     read address channel
//   rvalid/rdata/rready        read data channel
//   awvalid/awaddr/awready     write address channel
//   wvalid/wdata/wready        write data channel
//   bvalid/bresp/bready        write response (bresp: 0=OKAY, 2=SLVERR)
//   mem_req/mem_we/mem_addr    memory request; mem_addr is a word address
//   mem_wdata/mem_rdata        memory write / read data
//   mem_ready                  the access completes in a cycle with mem_req && mem_ready
// ---------------------------------------------------------------------------
module axi4_lite_mem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    // read address / data
    input  logic                                         arvalid,
    input  logic [ADDR_WIDTH-1:0]                        araddr,
    output logic                                         arready,
    output logic                                         rvalid,
    output logic [DATA_WIDTH-1:0]                        rdata,
    input  logic                                         rready,
    // write address / data / response
    input  logic                                         awvalid,
    input  logic [ADDR_WIDTH-1:0]                        awaddr,
    output logic                                         awready,
    input  logic                                         wvalid,
    input  logic [DATA_WIDTH-1:0]                        wdata,
    output logic                                         wready,
    output logic                                         bvalid,
    output logic [2:0]                                   bresp,
    input  logic                                         bready,
    // memory port
    output logic                                         mem_req,
    output logic                                         mem_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]                        mem_wdata,
    input  logic [DATA_WIDTH-1:0]                        mem_rdata,
    input  logic                                         mem_ready
);

    localparam int BOFF = $clog2(DATA_WIDTH/8);
    localparam int MAW  = ADDR_WIDTH - BOFF;

    localparam logic [2:0] RESP_OKAY   = 3'd0;
    localparam logic [2:0] RESP_SLVERR = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        MEM_RD,
        MEM_WR,
        RD_RESP,
        WR_RESP
    } state_t;

    state_t                state_reg;
    logic                  have_aw_reg;
    logic                  have_w_reg;
    logic                  last_rd_reg;
    logic                  aw_bad_reg;
    logic                  rvalid_reg;
    logic                  bvalid_reg;
    logic                  mem_req_reg;
    logic                  mem_we_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [2:0]            bresp_reg;
    logic [MAW-1:0]        mem_addr_reg;

    // Misalignment flags for the incoming addresses.
`ifdef AXI_MEM_BRIDGE_ALIGN_CHECK_EN
    logic ar_bad;
    logic aw_bad_in;
    assign ar_bad    = |araddr[BOFF-1:0];
    assign aw_bad_in = |awaddr[BOFF-1:0];
`else
    logic ar_bad;
    logic aw_bad_in;
    logic unused_addr_lo;
    assign ar_bad         = 1'b0;
    assign aw_bad_in      = 1'b0;
    // Byte-offset bits carry no meaning without the alignment check.
    assign unused_addr_lo = ^{araddr[BOFF-1:0], awaddr[BOFF-1:0]};
`endif

    // Read wins unless the previous IDLE grant went to a read and a write
    // is also waiting; this gives strict alternation under contention.
    logic rd_sel;
    assign rd_sel = arvalid && !(last_rd_reg && (awvalid || wvalid));

    assign arready = aresetn && (state_reg == IDLE) && rd_sel;
    assign awready = aresetn && (((state_reg == IDLE) && !rd_sel) ||
                                 ((state_reg == WR_COLLECT) && !have_aw_reg));
    assign wready  = aresetn && (((state_reg == IDLE) && !rd_sel) ||
                                 ((state_reg == WR_COLLECT) && !have_w_reg));

    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;

    // Misalignment of the write being launched: the address is either
    // arriving this cycle or was captured earlier in WR_COLLECT.
    logic wr_bad;
    assign wr_bad = aw_hs ? aw_bad_in : aw_bad_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            have_aw_reg   <= 1'b0;
            have_w_reg    <= 1'b0;
            last_rd_reg   <= 1'b0;
            aw_bad_reg    <= 1'b0;
            rvalid_reg    <= 1'b0;
            bvalid_reg    <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            rdata_reg     <= '0;
            mem_wdata_reg <= '0;
            bresp_reg     <= RESP_OKAY;
            mem_addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ar_hs) begin
                        last_rd_reg  <= 1'b1;
                        mem_addr_reg <= araddr[ADDR_WIDTH-1:BOFF];
                        if (ar_bad) begin
                            rdata_reg  <= '0;
                            rvalid_reg <= 1'b1;
                            state_reg  <= RD_RESP;
                        end else begin
                            mem_req_reg <= 1'b1;
                            mem_we_reg  <= 1'b0;
                            state_reg   <= MEM_RD;
                        end
                    end else if (aw_hs || w_hs) begin
                        last_rd_reg <= 1'b0;
                        if (aw_hs) begin
                            mem_addr_reg <= awaddr[ADDR_WIDTH-1:BOFF];
                            aw_bad_reg   <= aw_bad_in;
                        end
                        if (w_hs) begin
                            mem_wdata_reg <= wdata;
                        end
                        if (aw_hs && w_hs) begin
                            if (wr_bad) begin
                                bresp_reg  <= RESP_SLVERR;
                                bvalid_reg <= 1'b1;
                                state_reg  <= WR_RESP;
                            end else begin
                                mem_req_reg <= 1'b1;
                                mem_we_reg  <= 1'b1;
                                state_reg   <= MEM_WR;
                            end
                        end else begin
                            have_aw_reg <= aw_hs;
                            have_w_reg  <= w_hs;
                            state_reg   <= WR_COLLECT;
                        end
                    end
                end

                WR_COLLECT: begin
                    if (aw_hs) begin
                        mem_addr_reg <= awaddr[ADDR_WIDTH-1:BOFF];
                        aw_bad_reg   <= aw_bad_in;
                        have_aw_reg  <= 1'b1;
                    end
                    if (w_hs) begin
                        mem_wdata_reg <= wdata;
                        have_w_reg    <= 1'b1;
                    end
                    if ((have_aw_reg || aw_hs) && (have_w_reg || w_hs)) begin
                        have_aw_reg <= 1'b0;
                        have_w_reg  <= 1'b0;
                        if (wr_bad) begin
                            bresp_reg  <= RESP_SLVERR;
                            bvalid_reg <= 1'b1;
                            state_reg  <= WR_RESP;
                        end else begin
                            mem_req_reg <= 1'b1;
                            mem_we_reg  <= 1'b1;
                            state_reg   <= MEM_WR;
                        end
                    end
                end

                MEM_RD: begin
                    if (mem_ready) begin
                        rdata_reg   <= mem_rdata;
                        mem_req_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        state_reg   <= RD_RESP;
                    end
                end

                MEM_WR: begin
                    if (mem_ready) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        bresp_reg   <= RESP_OKAY;
                        bvalid_reg  <= 1'b1;
                        state_reg   <= WR_RESP;
                    end
                end

                RD_RESP: begin
                    if (rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end

                WR_RESP: begin
                    if (bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rvalid    = rvalid_reg;
    assign rdata     = rdata_reg;
    assign bvalid    = bvalid_reg;
    assign bresp     = bresp_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_axi4_lite_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_mem_bridge
//
// Directed bench for axi4_lite_mem_bridge (32-bit address/data). Expected read
// data, write responses and memory writes are queued as stimulus is driven and
// popped when the DUT produces the matching handshake. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Expectations follow AXI_MEM_BRIDGE_ALIGN_CHECK_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_axi4_lite_mem_bridge;

    logic        aclk;
    logic        aresetn;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic        wready;
    logic        bvalid;
    logic [2:0]  bresp;
    logic        bready;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    axi4_lite_mem_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .arready   (arready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rready    (rready),
        .awvalid   (awvalid),
        .awaddr    (awaddr),
        .awready   (awready),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wready    (wready),
        .bvalid    (bvalid),
        .bresp     (bresp),
        .bready    (bready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Memory model: combinational read, mem_ready after mem_lat wait cycles.
    logic [31:0] mem_model [0:63] = '{4: 32'hCAFEF00D, 5: 32'hA5A55A5A, default: 32'h0};
    int  mem_lat  = 0;
    bit  mem_hold = 1'b0;
    int  wcnt     = 0;

    always @(posedge aclk) begin
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    assign mem_ready = !mem_hold && (wcnt >= mem_lat);
    assign mem_rdata = mem_model[mem_addr[5:0]];

    // Scoreboard queues
    logic [31:0] exp_rd_q [$];
    logic [2:0]  exp_b_q  [$];
    logic [29:0] exp_wa_q [$];
    logic [31:0] exp_wd_q [$];

    int n_assert = 0;
    int n_fail   = 0;
    int mem_acc  = 0;
    bit ar_taken, aw_taken, w_taken;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes and score them on the falling edge,
    // then return 1 time unit after the next rising edge.
    task automatic cycle();
        logic [31:0] e32;
        logic [29:0] ea;
        logic [2:0]  eb;
        @(negedge aclk);
        ar_taken = arvalid && arready;
        aw_taken = awvalid && awready;
        w_taken  = wvalid && wready;
        if (aresetn) begin
            if (rvalid && rready) begin
                $display("R  rdata=%08h", rdata);
                chk("r_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) begin
                    e32 = exp_rd_q.pop_front();
                    chk("rdata", 64'(rdata), 64'(e32));
                end
            end
            if (bvalid && bready) begin
                $display("B  bresp=%0d", bresp);
                chk("b_expected", 64'(exp_b_q.size() != 0), 64'd1);
                if (exp_b_q.size() != 0) begin
                    eb = exp_b_q.pop_front();
                    chk("bresp", 64'(bresp), 64'(eb));
                end
            end
            if (mem_req && mem_ready) begin
                mem_acc++;
                if (mem_we) begin
                    $display("MW addr=%0h data=%08h", mem_addr, mem_wdata);
                    mem_model[mem_addr[5:0]] = mem_wdata;
                    chk("memwr_expected", 64'(exp_wa_q.size() != 0), 64'd1);
                    if (exp_wa_q.size() != 0) begin
                        ea  = exp_wa_q.pop_front();
                        e32 = exp_wd_q.pop_front();
                        chk("memwr_addr", 64'(mem_addr), 64'(ea));
                        chk("memwr_data", 64'(mem_wdata), 64'(e32));
                    end
                end else begin
                    $display("MR addr=%0h data=%08h", mem_addr, mem_rdata);
                end
            end
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int acc0;
    int ngr;
    int order [0:7];

    initial begin
        aresetn = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
        bready  = 1'b1;

        // ---------------- reset state ----------------
        cycle();
        cycle();
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we",  64'(mem_we),  64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        chk("rst_bresp",   64'(bresp),   64'd0);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        cycle();
        aresetn = 1'b1;

        // ---------------- T1: zero-wait read ----------------
        arvalid = 1'b1; araddr = 32'h10;
        exp_rd_q.push_back(32'hCAFEF00D);
        cycle();                                   // AR handshake at N
        chk("t1_ar_taken", 64'(ar_taken), 64'd1);
        arvalid = 1'b0;
        chk("t1_mem_req", 64'(mem_req), 64'd1);    // N+1
        chk("t1_mem_addr", 64'(mem_addr), 64'd4);
        chk("t1_mem_we", 64'(mem_we), 64'd0);
        cycle();
        chk("t1_rvalid", 64'(rvalid), 64'd1);      // N+2
        chk("t1_rdata", 64'(rdata), 64'hCAFEF00D);
        cycle();
        chk("t1_rvalid_drop", 64'(rvalid), 64'd0);

        // ---------------- T2: W two cycles before AW ----------------
        wvalid = 1'b1; wdata = 32'h12345678;
        cycle();
        chk("t2_w_taken", 64'(w_taken), 64'd1);
        wvalid = 1'b0;
        exp_wa_q.push_back(30'd8); exp_wd_q.push_back(32'h12345678);
        exp_b_q.push_back(3'd0);
        arvalid = 1'b1; araddr = 32'h10;
        exp_rd_q.push_back(32'hCAFEF00D);
        cycle();
        chk("t2_no_ar_collect1", 64'(ar_taken), 64'd0);
        cycle();
        chk("t2_no_ar_collect2", 64'(ar_taken), 64'd0);
        awvalid = 1'b1; awaddr = 32'h20;
        cycle();
        chk("t2_aw_taken", 64'(aw_taken), 64'd1);
        chk("t2_no_ar_collect3", 64'(ar_taken), 64'd0);
        awvalid = 1'b0;
        chk("t2_mem_req", 64'(mem_req), 64'd1);
        chk("t2_mem_we", 64'(mem_we), 64'd1);
        chk("t2_mem_addr", 64'(mem_addr), 64'd8);
        chk("t2_mem_wdata", 64'(mem_wdata), 64'h12345678);
        cycle();
        chk("t2_bvalid", 64'(bvalid), 64'd1);
        chk("t2_bresp", 64'(bresp), 64'd0);
        cycle();
        cycle();
        chk("t2_ar_after_write", 64'(ar_taken), 64'd1);
        arvalid = 1'b0;
        cycle();
        cycle();

        // ---------------- T3: 3 wait states, rready low 4 cycles ----------------
        mem_lat = 3; rready = 1'b0;
        acc0 = mem_acc;
        arvalid = 1'b1; araddr = 32'h14;
        exp_rd_q.push_back(32'hA5A55A5A);
        cycle();
        chk("t3_ar_taken", 64'(ar_taken), 64'd1);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_mem_req_stable", 64'(mem_req), 64'd1);
            chk("t3_mem_addr_stable", 64'(mem_addr), 64'd5);
            chk("t3_no_rvalid_yet", 64'(rvalid), 64'd0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_rvalid_stable", 64'(rvalid), 64'd1);
            chk("t3_rdata_stable", 64'(rdata), 64'hA5A55A5A);
            chk("t3_mem_req_low", 64'(mem_req), 64'd0);
            cycle();
        end
        rready = 1'b1;
        cycle();
        chk("t3_rvalid_drop", 64'(rvalid), 64'd0);
        chk("t3_one_access", 64'(mem_acc - acc0), 64'd1);
        mem_lat = 0;

        // ---------------- T5: reset during MEM_WR ----------------
        mem_hold = 1'b1;
        awvalid = 1'b1; awaddr = 32'h40; wvalid = 1'b1; wdata = 32'hDEADBEEF;
        cycle();
        chk("t5_aw_taken", 64'(aw_taken && w_taken), 64'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t5_mem_req", 64'(mem_req), 64'd1);
        cycle();
        chk("t5_mem_req_held", 64'(mem_req), 64'd1);
        aresetn = 1'b0;
        cycle();
        chk("t5_mem_req_abort", 64'(mem_req), 64'd0);
        chk("t5_bvalid_abort", 64'(bvalid), 64'd0);
        chk("t5_awready_in_rst", 64'(awready), 64'd0);
        aresetn = 1'b1;
        mem_hold = 1'b0;
        #1;
        chk("t5_awready_release", 64'(awready), 64'd1);
        chk("t5_wready_release", 64'(wready), 64'd1);
        acc0 = mem_acc;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_no_bvalid", 64'(bvalid), 64'd0);
        end
        chk("t5_no_access", 64'(mem_acc - acc0), 64'd0);

        // ---------------- T4: contention after reset ----------------
        arvalid = 1'b1; araddr = 32'h10;
        awvalid = 1'b1; awaddr = 32'h30; wvalid = 1'b1; wdata = 32'h11110000;
        exp_rd_q.push_back(32'hCAFEF00D); exp_rd_q.push_back(32'hCAFEF00D);
        exp_wa_q.push_back(30'd12); exp_wd_q.push_back(32'h11110000);
        exp_wa_q.push_back(30'd12); exp_wd_q.push_back(32'h22220000);
        exp_b_q.push_back(3'd0); exp_b_q.push_back(3'd0);
        ngr = 0;
        for (int i = 0; i < 60 && ngr < 4; i++) begin
            cycle();
            if (ar_taken && ngr < 8) begin
                $display("G  read");
                order[ngr] = 0; ngr++;
            end
            if (aw_taken && w_taken && ngr < 8) begin
                $display("G  write");
                order[ngr] = 1; ngr++;
                wdata = 32'h22220000;
            end
            if (ngr >= 4) begin
                arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
            end
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("t4_grant_count", 64'(ngr), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t4_order", 64'(order[k]), 64'(k % 2));
        end
        for (int i = 0; i < 4; i++) cycle();

        // ---------------- T6: misaligned write and read ----------------
        acc0 = mem_acc;
        awvalid = 1'b1; awaddr = 32'h22; wvalid = 1'b1; wdata = 32'h55AA55AA;
`ifdef AXI_MEM_BRIDGE_ALIGN_CHECK_EN
        exp_b_q.push_back(3'd2);
`else
        exp_wa_q.push_back(30'd8); exp_wd_q.push_back(32'h55AA55AA);
        exp_b_q.push_back(3'd0);
`endif
        cycle();
        chk("t6_aw_taken", 64'(aw_taken && w_taken), 64'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        arvalid = 1'b1; araddr = 32'h11;
`ifdef AXI_MEM_BRIDGE_ALIGN_CHECK_EN
        exp_rd_q.push_back(32'h0);
`else
        exp_rd_q.push_back(32'hCAFEF00D);
`endif
        cycle();
        chk("t6_ar_taken", 64'(ar_taken), 64'd1);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
`ifdef AXI_MEM_BRIDGE_ALIGN_CHECK_EN
        chk("t6_mem_accesses", 64'(mem_acc - acc0), 64'd0);
        chk("t6_word8", 64'(mem_model[8]), 64'h12345678);
`else
        chk("t6_mem_accesses", 64'(mem_acc - acc0), 64'd2);
        chk("t6_word8", 64'(mem_model[8]), 64'h55AA55AA);
`endif

        // ---------------- final scoreboard state ----------------
        chk("end_word16_untouched", 64'(mem_model[16]), 64'd0);
        chk("end_word12", 64'(mem_model[12]), 64'h22220000);
        chk("end_rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
        chk("end_b_q_empty", 64'(exp_b_q.size()), 64'd0);
        chk("end_wr_q_empty", 64'(exp_wa_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
